mips_alu_ctrl_mem: RTL and testbench
====================================

# mips_alu_ctrl_mem

Combined execute/memory support block for the 5-stage pipelined MIPS core. It provides three functions:

- the main instruction decoder, used in IF/ID;
- the 32-bit ALU, used in EX;
- the 32-word data memory, used in MEM.

The pipeline registers, register file and PC logic sit outside this block. Decode and ALU are purely combinational. The data memory writes synchronously and reads combinationally.

## Interface
Parameters:
- DMEM_WORDS, 32, number of 32-bit data memory words (addressed by Addr[6:2]).

Ports:
- CLK  in  1  rising-edge clock.
- RSTn  in  1  reset: one clock; asynchronous, active-low.
- Op  in  6  opcode, instr[31:26].
- Funct  in  6  function field, instr[5:0].
- JtoPC, Branch, RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg  out  1 each  decoded controls.
- ALUOp  out  4  decoded ALU operation.
- ALUCtl  in  4  ALU operation applied to the ALU (fed from the pipeline).
- A, B  in  32  ALU operands.
- Result  out  32  ALU result.
- Zero  out  1  high when Result == 0.
- DmWrite, DmRead  in  1  memory write/read enables (from the MEM stage).
- Addr  in  7  byte address; Addr[1:0] ignored.
- WData  in  32  store data.
- RData  out  32  load data.

## Operation
Decode (combinational):
- Op 000000 (R-type): RegWrite=1, RegDst=1. ALUOp is selected by Funct:
  - 100000 → 0010 (add)
  - 100010 → 0110 (sub)
  - 100100 → 0000 (and)
  - 100101 → 0001 (or)
  - 100111 → 1100 (nor)
  - 101010 → 0111 (slt)
- Any other Funct under R-type: all controls 0.
- 100011 lw: RegWrite, ALUSrc, MemRead, MemtoReg = 1; ALUOp 0010.
- 101011 sw: ALUSrc, MemWrite = 1; ALUOp 0010.
- 001000 addi: RegWrite, ALUSrc = 1; ALUOp 0010.
- 000100 beq: Branch=1; ALUOp 0110.
- 000010 j: JtoPC=1; ALUOp 0000.
- Any other opcode: all controls 0 and ALUOp 0000 (bubble/NOP).

ALU (combinational, on ALUCtl):
- AND, OR, ADD, SUB and NOR as 32-bit operations.
- ADD/SUB wrap modulo 2^32; there is no overflow flag.
- SLT gives 1 when $signed(A) < $signed(B), else 0.
- Undefined codes give Result = 0.
- Zero = (Result == 0).

Data memory:
- Index is Addr[6:2], so words 0..31.
- Write: on the rising CLK edge when DmWrite=1, mem[Addr[6:2]] ← WData.
- Read: RData = DmRead ? mem[Addr[6:2]] : 0, combinational.
- Simultaneous DmRead and DmWrite to the same word: RData shows the old contents until the edge, then the new contents.

Reset:
- RSTn low asynchronously clears all memory words to 0, so RData reads 0 while in reset.
- Writes are ignored while RSTn is low.
- Decode and ALU outputs are combinational and unaffected by reset.

## Timing
- Decode, ALU and the memory read path have zero-cycle latency. They must settle within one CLK period.
- A store has one-edge latency: data written at edge N is readable immediately after edge N.
- Deassertion of RSTn takes effect at the next edge. The first write accepted is at the first rising edge with RSTn high.
- No handshake: the enables are sampled every edge.

## Configuration
Macro: ALU_SLT_EN.
- Defined:
  - ALUCtl 0111 computes signed SLT.
  - Funct 101010 decodes to RegWrite=1, RegDst=1, ALUOp 0111.
- Not defined:
  - ALUCtl 0111 is undefined (Result = 0, Zero = 1).
  - Funct 101010 decodes as an unsupported R-type (all controls 0).

## Test plan
- Decode sweep:
  - Op 100011 → RegWrite/ALUSrc/MemRead/MemtoReg = 1, ALUOp 0010.
  - Op 000010 → only JtoPC = 1.
  - Op 111111 → all 0.
- ALU arithmetic:
  - ADD 0xFFFFFFFF + 1 → 0, Zero = 1.
  - SUB 5 − 7 → 0xFFFFFFFE.
  - NOR 0 , 0 → 0xFFFFFFFF.
- SLT (with ALU_SLT_EN):
  - A = 0xFFFFFFFF, B = 1 → 1.
  - A = 1, B = 0xFFFFFFFF → 0, Zero = 1.
- Store/load:
  - Write 0xDEADBEEF at Addr 0x0C (DmWrite one edge), then DmRead Addr 0x0F → 0xDEADBEEF.
  - DmRead = 0 → RData 0.
- Reset mid-operation:
  - Fill word 3, pull RSTn low between edges → RData at Addr 0x0C reads 0 immediately.
  - Writes during reset are dropped.
- Macro off: Funct 101010 under Op 0 → all controls 0; ALUCtl 0111 → Result 0.

Source files
------------

// File: rtl/mips_alu_ctrl_mem.sv
// Execute/memory support block for the 5-stage MIPS core: main decoder, 32-bit ALU, word data memory.
// Optional macro ALU_SLT_EN enables the signed set-less-than ALU op and its R-type decode.
module mips_alu_ctrl_mem #(
  parameter int unsigned DMEM_WORDS = 32
) (
  input  logic        CLK,
  input  logic        RSTn,
  // decoder
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  output logic        JtoPC,
  output logic        Branch,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic [3:0]  ALUOp,
  // ALU
  input  logic [3:0]  ALUCtl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        Zero,
  // data memory
  input  logic        DmWrite,
  input  logic        DmRead,
  input  logic [6:0]  Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
`ifdef ALU_SLT_EN
  localparam logic [5:0] FN_SLT   = 6'b101010;
`endif

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
`ifdef ALU_SLT_EN
  localparam logic [3:0] ALU_SLT  = 4'b0111;
`endif

  // ---------------------------------------------------------------- decode
  logic       w_rtype_ok;
  logic [3:0] w_rtype_op;

  always_comb begin
    w_rtype_ok = 1'b1;
    w_rtype_op = ALU_AND;
    case (Funct)
      FN_ADD:  w_rtype_op = ALU_ADD;
      FN_SUB:  w_rtype_op = ALU_SUB;
      FN_AND:  w_rtype_op = ALU_AND;
      FN_OR:   w_rtype_op = ALU_OR;
      FN_NOR:  w_rtype_op = ALU_NOR;
`ifdef ALU_SLT_EN
      FN_SLT:  w_rtype_op = ALU_SLT;
`endif
      default: w_rtype_ok = 1'b0;
    endcase
  end

  // Unsupported opcodes and unsupported R-type functs both decode to a bubble.
  always_comb begin
    JtoPC    = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    MemtoReg = 1'b0;
    ALUOp    = ALU_AND;
    case (Op)
      OP_RTYPE: begin
        if (w_rtype_ok) begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          ALUOp    = w_rtype_op;
        end
      end
      OP_LW: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        MemRead  = 1'b1;
        MemtoReg = 1'b1;
        ALUOp    = ALU_ADD;
      end
      OP_SW: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
        ALUOp    = ALU_ADD;
      end
      OP_ADDI: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        ALUOp    = ALU_ADD;
      end
      OP_BEQ: begin
        Branch   = 1'b1;
        ALUOp    = ALU_SUB;
      end
      OP_J: begin
        JtoPC    = 1'b1;
        ALUOp    = ALU_AND;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------- ALU
  always_comb begin
    Result = '0;
    case (ALUCtl)
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_NOR: Result = ~(A | B);
`ifdef ALU_SLT_EN
      ALU_SLT: Result = {31'b0, $signed(A) < $signed(B)};
`endif
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

  // ---------------------------------------------------------- data memory
  logic [31:0] r_mem [DMEM_WORDS];
  logic [4:0]  w_idx;
  logic        w_idx_ok;
  logic        w_unused_byte_addr;

  assign w_idx              = Addr[6:2];
  assign w_idx_ok           = (32'(w_idx) < DMEM_WORDS);
  assign w_unused_byte_addr = ^Addr[1:0];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < DMEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (DmWrite && w_idx_ok) begin
      r_mem[w_idx] <= WData;
    end
  end

  // Read is combinational: a same-word write shows up only after the edge.
  assign RData = (DmRead && w_idx_ok) ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_mips_alu_ctrl_mem.sv
// Randomized self-checking bench for mips_alu_ctrl_mem against a behavioural reference model.
// Honours ALU_SLT_EN the same way the design does.
module tb_mips_alu_ctrl_mem;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [5:0]  Op, Funct;
  logic        JtoPC, Branch, RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg;
  logic [3:0]  ALUOp, ALUCtl;
  logic [31:0] A, B, Result;
  logic        Zero;
  logic        DmWrite, DmRead;
  logic [6:0]  Addr;
  logic [31:0] WData, RData;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_ref [32];
  int unsigned rfunct_op [int unsigned];

  mips_alu_ctrl_mem #(.DMEM_WORDS(32)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Op(Op), .Funct(Funct),
    .JtoPC(JtoPC), .Branch(Branch), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .ALUOp(ALUOp),
    .ALUCtl(ALUCtl), .A(A), .B(B), .Result(Result), .Zero(Zero),
    .DmWrite(DmWrite), .DmRead(DmRead), .Addr(Addr), .WData(WData), .RData(RData)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Control vector {JtoPC,Branch,RegWrite,RegDst,ALUSrc,MemWrite,MemRead,MemtoReg,ALUOp[3:0]}
  function automatic logic [31:0] decode_ref(input logic [5:0] op, input logic [5:0] fn);
    logic [7:0] f;
    logic [3:0] aop;
    f   = 8'h00;
    aop = 4'h0;
    if (op == 6'd0) begin
      if (rfunct_op.exists(int'(fn))) begin
        f   = 8'b0011_0000;
        aop = 4'(rfunct_op[int'(fn)]);
      end
    end else if (op == 6'b100011) begin f = 8'b0010_1011; aop = 4'd2; end
    else if (op == 6'b101011)     begin f = 8'b0000_1100; aop = 4'd2; end
    else if (op == 6'b001000)     begin f = 8'b0010_1000; aop = 4'd2; end
    else if (op == 6'b000100)     begin f = 8'b0100_0000; aop = 4'd6; end
    else if (op == 6'b000010)     begin f = 8'b1000_0000; aop = 4'd0; end
    return {20'd0, f, aop};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned la, lb, two32;
    la = 64'(a);
    lb = 64'(b);
    two32 = 64'h1_0000_0000;
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return 32'((la + lb) % two32);
      4'd6:  return 32'((la + two32 - lb) % two32);
      4'd12: return ~(a | b);
`ifdef ALU_SLT_EN
      4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] got_decode();
    return {20'd0, JtoPC, Branch, RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg, ALUOp};
  endfunction

  task automatic chk_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    Op = op; Funct = fn;
    #1;
    check(tag, got_decode(), decode_ref(op, fn));
  endtask

  task automatic chk_alu(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    ALUCtl = c; A = a; B = b;
    #1;
    exp = alu_ref(c, a, b);
    check({tag, "_res"}, Result, exp);
    check({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
  endtask

  function automatic logic [31:0] rdata_ref();
    return DmRead ? mem_ref[Addr[6:2]] : 32'd0;
  endfunction

  // Drive a memory cycle at the negedge, check before and after the following posedge.
  task automatic mem_cycle(input string tag, input logic we, input logic re,
                           input logic [6:0] ad, input logic [31:0] wd);
    @(negedge CLK);
    DmWrite = we; DmRead = re; Addr = ad; WData = wd;
    #1;
    check({tag, "_pre"}, RData, rdata_ref());
    @(posedge CLK);
    if (RSTn && we) mem_ref[ad[6:2]] = wd;
    #1;
    check({tag, "_post"}, RData, rdata_ref());
  endtask

  logic [5:0]  ops   [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010, 6'b111111};
  logic [5:0]  fns   [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000};
  logic [31:0] edges [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rfunct_op[32'b100000] = 4'b0010;
    rfunct_op[32'b100010] = 4'b0110;
    rfunct_op[32'b100100] = 4'b0000;
    rfunct_op[32'b100101] = 4'b0001;
    rfunct_op[32'b100111] = 4'b1100;
`ifdef ALU_SLT_EN
    rfunct_op[32'b101010] = 4'b0111;
`endif
    for (int i = 0; i < 32; i++) mem_ref[i] = 32'd0;

    RSTn = 1'b0; Op = '0; Funct = '0; ALUCtl = '0; A = '0; B = '0;
    DmWrite = 1'b0; DmRead = 1'b1; Addr = 7'h0C; WData = '0;
    #1;
    check("reset_rdata", RData, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RSTn = 1'b1;

    // decode: directed then random
    chk_decode("dec_lw", 6'b100011, 6'b000000);
    chk_decode("dec_j", 6'b000010, 6'b111111);
    chk_decode("dec_ff", 6'b111111, 6'b100000);
    chk_decode("dec_slt_funct", 6'b000000, 6'b101010);
    chk_decode("dec_bad_funct", 6'b000000, 6'b000000);
    for (int i = 0; i < 7; i++) chk_decode("dec_sweep", ops[i], fns[i % 5]);
    for (int i = 0; i < 200; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      chk_decode("dec_rand", op, fn);
    end

    // ALU: directed then random
    chk_alu("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1);
    chk_alu("sub_neg", 4'b0110, 32'd5, 32'd7);
    chk_alu("nor_zero", 4'b1100, 32'd0, 32'd0);
    chk_alu("slt_neg1_1", 4'b0111, 32'hFFFF_FFFF, 32'h1);
    chk_alu("slt_1_neg1", 4'b0111, 32'h1, 32'hFFFF_FFFF);
    chk_alu("undef_ctl", 4'b1111, 32'h1234, 32'h5678);
    for (int i = 0; i < 300; i++)
      chk_alu("alu_rand", 4'($urandom_range(0, 15)), pick_operand(), pick_operand());

    // store / load
    mem_cycle("st_dead", 1'b1, 1'b0, 7'h0C, 32'hDEAD_BEEF);
    mem_cycle("ld_0f",   1'b0, 1'b1, 7'h0F, 32'h0);
    check("ld_0f_val", RData, 32'hDEAD_BEEF);
    mem_cycle("rd_off",  1'b0, 1'b0, 7'h0C, 32'h0);
    mem_cycle("rw_same", 1'b1, 1'b1, 7'h0D, 32'hCAFE_F00D);
    for (int i = 0; i < 300; i++)
      mem_cycle("mem_rand", 1'($urandom), ($urandom_range(0, 3) != 0), 7'($urandom), $urandom);

    // reset in the middle of operation
    mem_cycle("fill_w3", 1'b1, 1'b1, 7'h0C, 32'hA5A5_5A5A);
    @(negedge CLK);
    DmWrite = 1'b0; DmRead = 1'b1; Addr = 7'h0C;
    #2;
    RSTn = 1'b0;
    for (int i = 0; i < 32; i++) mem_ref[i] = 32'd0;
    #1;
    check("rst_async_clear", RData, 32'd0);
    mem_cycle("wr_in_rst_a", 1'b1, 1'b1, 7'h0C, 32'h1111_1111);
    mem_cycle("wr_in_rst_b", 1'b1, 1'b1, 7'h40, 32'h2222_2222);
    Addr = 7'h40;
    #1;
    check("rst_dropped_w16", RData, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    DmWrite = 1'b1; DmRead = 1'b1; Addr = 7'h0C; WData = 32'h3333_3333;
    #1;
    check("rst_release_pre", RData, 32'd0);
    @(posedge CLK);
    mem_ref[3] = 32'h3333_3333;
    #1;
    check("first_write_after_rst", RData, 32'h3333_3333);
    for (int i = 0; i < 50; i++)
      mem_cycle("mem_rand2", 1'($urandom), 1'b1, 7'($urandom), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
